// File: rtl/e1_rx_clock_recovery_dpll.sv
// E1 receive clock recovery DPLL.
// A free-running phase counter is steered by line edge strobes, either by
// forcing it back into alignment on every edge or by nudging it at most
// MAX_ADJ counts per edge. One sample strobe is issued per bit period, and
// lock / loss-of-signal status is tracked from how edges line up with the
// counter.
module e1_rx_clock_recovery_dpll #(
    parameter int PERIOD_W   = 5,
    parameter int NOM_PERIOD = 15,
    parameter int SAMPLE_OFS = 2,
    parameter int HARD_SYNC  = 0,
    parameter int MAX_ADJ    = 1,
    parameter int WINDOW     = 3,
    parameter int LOCK_CNT   = 16,
    parameter int LOS_BITS   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic in_hi,
    input  logic in_lo,
    input  logic in_stb,
    output logic out_hi,
    output logic out_lo,
    output logic out_stb,
    output logic locked,
    output logic los
);

    // The error path is two bits wider than the phase counter. This leaves
    // room for the sign, and for p + 1 + adj before it is folded back mod N.
    localparam int ERR_W  = PERIOD_W + 2;
    localparam int LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int LOS_W  = $clog2(LOS_BITS + 1);

    localparam logic signed [ERR_W-1:0] NOM_S  = ERR_W'(NOM_PERIOD);
    localparam logic signed [ERR_W-1:0] HALF_S = ERR_W'(NOM_PERIOD / 2);
    localparam logic signed [ERR_W-1:0] WIN_S  = ERR_W'(WINDOW);
    localparam logic signed [ERR_W-1:0] ADJ_S  = ERR_W'(MAX_ADJ);
    localparam logic signed [ERR_W-1:0] ONE_S  = ERR_W'(1);

    localparam logic [PERIOD_W-1:0] PH_LAST   = PERIOD_W'(NOM_PERIOD - 1);
    localparam logic [PERIOD_W-1:0] PH_SAMPLE = PERIOD_W'(SAMPLE_OFS);
    localparam logic [PERIOD_W-1:0] PH_SYNC   = PERIOD_W'(1);
    localparam logic [LOCK_W-1:0]   LOCK_MAX  = LOCK_W'(LOCK_CNT);
    localparam logic [LOS_W-1:0]    LOS_MAX   = LOS_W'(LOS_BITS);

    // Signed phase error of an edge seen at counter value p.
    // Edges in the first half of the period mean the counter is ahead
    // (positive error). Edges in the second half mean it is behind.
    function automatic logic signed [ERR_W-1:0] phase_err(input logic [PERIOD_W-1:0] p);
        logic signed [ERR_W-1:0] ps;
        ps = signed'({2'b00, p});
        if (ps <= HALF_S) begin
            return ps;
        end
        return ps - NOM_S;
    endfunction

    // Saturate a non-negative correction magnitude to MAX_ADJ.
    function automatic logic signed [ERR_W-1:0] clamp_adj(input logic signed [ERR_W-1:0] mag);
        return (mag > ADJ_S) ? ADJ_S : mag;
    endfunction

    // Absolute value of the phase error, used for the lock window.
    function automatic logic signed [ERR_W-1:0] err_mag(input logic signed [ERR_W-1:0] e);
        return (e < 0) ? -e : e;
    endfunction

    // Next phase under bounded soft correction. The counter first advances
    // by one as usual. It is then pulled back by the error, or pushed
    // forward by it, by at most MAX_ADJ, and the result is folded back into
    // the range 0..N-1.
    function automatic logic [PERIOD_W-1:0] soft_next(input logic [PERIOD_W-1:0] p,
                                                      input logic signed [ERR_W-1:0] e);
        logic signed [ERR_W-1:0] nxt;
        nxt = signed'({2'b00, p}) + ONE_S;
        if (e > 0) begin
            nxt = nxt - clamp_adj(e);
        end else if (e < 0) begin
            nxt = nxt + clamp_adj(-e);
        end
        if (nxt >= NOM_S) begin
            nxt = nxt - NOM_S;
        end
        return PERIOD_W'(nxt);
    endfunction

    logic [PERIOD_W-1:0] ph_q,       ph_d;
    logic                out_stb_q,  out_stb_d;
    logic                out_hi_q,   out_hi_d;
    logic                out_lo_q,   out_lo_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                locked_q,   locked_d;
    logic [LOS_W-1:0]    los_cnt_q,  los_cnt_d;
    logic                los_q,      los_d;

    logic signed [ERR_W-1:0] err;
    logic                    in_win;
    logic                    wrap;

    // Next-state logic: phase steering, sampling, lock and loss-of-signal.
    always_comb begin
        ph_d       = ph_q;
        out_stb_d  = 1'b0;
        out_hi_d   = out_hi_q;
        out_lo_d   = out_lo_q;
        lock_cnt_d = lock_cnt_q;
        los_cnt_d  = los_cnt_q;
        los_d      = los_q;

        err    = phase_err(ph_q);
        in_win = (err_mag(err) <= WIN_S);
        wrap   = (ph_q == PH_LAST) && !in_stb;

        // The sample decision uses the current phase, so an edge arriving
        // on the sample phase does not cancel the strobe.
        if (ph_q == PH_SAMPLE) begin
            out_stb_d = 1'b1;
            out_hi_d  = in_hi;
            out_lo_d  = in_lo;
        end

        // An edge takes priority over the plain increment and wrap.
        if (in_stb) begin
            if (HARD_SYNC != 0) begin
                ph_d = PH_SYNC;
            end else begin
                ph_d = soft_next(ph_q, err);
            end
        end else if (wrap) begin
            ph_d = '0;
        end else begin
            ph_d = ph_q + 1'b1;
        end

        if (in_stb) begin
            if (in_win) begin
                if (lock_cnt_q != LOCK_MAX) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end else begin
                lock_cnt_d = '0;
            end
        end

        // The silence counter counts wraps of the phase counter. Any edge
        // clears it.
        if (in_stb) begin
            los_cnt_d = '0;
            los_d     = 1'b0;
        end else if (wrap && (los_cnt_q != LOS_MAX)) begin
            los_cnt_d = los_cnt_q + 1'b1;
        end

        // Once LOS_BITS silent periods are reached, lock is abandoned.
        if (!in_stb && (los_cnt_d == LOS_MAX)) begin
            los_d      = 1'b1;
            lock_cnt_d = '0;
        end

        locked_d = (lock_cnt_d == LOCK_MAX);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q       <= '0;
            out_stb_q  <= 1'b0;
            out_hi_q   <= 1'b0;
            out_lo_q   <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            los_cnt_q  <= '0;
            los_q      <= 1'b1;
        end else begin
            ph_q       <= ph_d;
            out_stb_q  <= out_stb_d;
            out_hi_q   <= out_hi_d;
            out_lo_q   <= out_lo_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            los_cnt_q  <= los_cnt_d;
            los_q      <= los_d;
        end
    end

    assign out_stb = out_stb_q;
    assign out_hi  = out_hi_q;
    assign out_lo  = out_lo_q;
    assign locked  = locked_q;
    assign los     = los_q;

endmodule

// File: tb/tb_e1_rx_clock_recovery_dpll.sv
// Directed bench for e1_rx_clock_recovery_dpll.
// A soft-correction instance and a hard-sync instance share the same
// stimulus. Expected cycle numbers below count clock edges after reset
// release (tick 1 is the first edge with rst low).
module tb_e1_rx_clock_recovery_dpll;

    logic clk;
    logic rst;
    logic in_hi;
    logic in_lo;
    logic in_stb;

    logic s_hi, s_lo, s_stb, s_locked, s_los;
    logic h_hi, h_lo, h_stb, h_locked, h_los;

    int total;
    int bad;

    e1_rx_clock_recovery_dpll u_soft (
        .clk(clk), .rst(rst), .in_hi(in_hi), .in_lo(in_lo), .in_stb(in_stb),
        .out_hi(s_hi), .out_lo(s_lo), .out_stb(s_stb), .locked(s_locked), .los(s_los)
    );

    e1_rx_clock_recovery_dpll #(.HARD_SYNC(1)) u_hard (
        .clk(clk), .rst(rst), .in_hi(in_hi), .in_lo(in_lo), .in_stb(in_stb),
        .out_hi(h_hi), .out_lo(h_lo), .out_stb(h_stb), .locked(h_locked), .los(h_los)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_stb = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // In-stb during reset is ignored. After release, with no edges, the
    // strobe is first seen at tick 3 and then every 15 ticks.
    task automatic test_reset();
        logic exp;
        rst = 1'b1; in_stb = 1'b1; in_hi = 1'b1; in_lo = 1'b0;
        tick(); tick();
        total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %0b want 0", s_stb); end
        total++; if (s_los !== 1'b1) begin bad++; $display("FAIL reset_los: got %0b want 1", s_los); end
        total++; if (s_locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %0b want 0", s_locked); end
        total++; if (s_hi !== 1'b0 || s_lo !== 1'b0) begin bad++; $display("FAIL reset_data: got %0b%0b want 00", s_hi, s_lo); end
        total++; if (h_stb !== 1'b0 || h_los !== 1'b1) begin bad++; $display("FAIL reset_hard: got stb=%0b los=%0b want 0 1", h_stb, h_los); end
        rst = 1'b0; in_stb = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            exp = (k == 3 || k == 18 || k == 33);
            total++; if (s_stb !== exp) begin bad++; $display("FAIL free_stb_soft k=%0d: got %0b want %0b", k, s_stb, exp); end
            total++; if (h_stb !== exp) begin bad++; $display("FAIL free_stb_hard k=%0d: got %0b want %0b", k, h_stb, exp); end
            total++; if (s_los !== 1'b1 || s_locked !== 1'b0) begin bad++; $display("FAIL free_status k=%0d: got los=%0b locked=%0b want 1 0", k, s_los, s_locked); end
            if (k == 2) begin
                total++; if (s_hi !== 1'b0) begin bad++; $display("FAIL free_hold k=2: got %0b want 0", s_hi); end
            end
            if (k == 3) begin
                total++; if (s_hi !== 1'b1 || s_lo !== 1'b0) begin bad++; $display("FAIL free_sample: got %0b%0b want 10", s_hi, s_lo); end
            end
        end
    endtask

    // Edges every 15 ticks, starting at phase 5. The phases step down
    // 5,4,3,... and then stay at 0. Edges 1 and 2 (|e| = 5 and 4) fall
    // outside the window, so the 16th in-window edge is edge 18, at tick
    // 261. A later edge at phase 10 (e = -5) shortens one period to 14
    // and drops lock.
    task automatic test_soft_lock();
        do_reset();
        for (int k = 1; k <= 278; k++) begin
            in_stb = ((k >= 6 && k <= 261 && ((k - 6) % 15) == 0) || k == 271);
            if (k == 263) begin in_hi = 1'b0; in_lo = 1'b1; end
            else begin in_hi = 1'b1; in_lo = 1'b0; end
            tick();
            case (k)
                5:   begin total++; if (s_los !== 1'b1) begin bad++; $display("FAIL soft_los_pre: got %0b want 1", s_los); end end
                6:   begin total++; if (s_los !== 1'b0) begin bad++; $display("FAIL soft_los_clear: got %0b want 0", s_los); end end
                260: begin total++; if (s_locked !== 1'b0) begin bad++; $display("FAIL soft_lock_early: got %0b want 0", s_locked); end end
                261: begin total++; if (s_locked !== 1'b1) begin bad++; $display("FAIL soft_lock_16: got %0b want 1", s_locked); end end
                262: begin total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL soft_stb_262: got %0b want 0", s_stb); end end
                263: begin
                    total++; if (s_stb !== 1'b1) begin bad++; $display("FAIL soft_stb_263: got %0b want 1", s_stb); end
                    total++; if (s_hi !== 1'b0 || s_lo !== 1'b1) begin bad++; $display("FAIL soft_sample: got %0b%0b want 01", s_hi, s_lo); end
                end
                264: begin total++; if (s_hi !== 1'b0 || s_lo !== 1'b1) begin bad++; $display("FAIL soft_hold: got %0b%0b want 01", s_hi, s_lo); end end
                270: begin total++; if (s_locked !== 1'b1) begin bad++; $display("FAIL oow_pre: got %0b want 1", s_locked); end end
                271: begin total++; if (s_locked !== 1'b0) begin bad++; $display("FAIL oow_unlock: got %0b want 0", s_locked); end end
                276: begin total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL oow_stb_276: got %0b want 0", s_stb); end end
                277: begin total++; if (s_stb !== 1'b1) begin bad++; $display("FAIL oow_stb_277: got %0b want 1", s_stb); end end
                278: begin total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL oow_stb_278: got %0b want 0", s_stb); end end
                default: ;
            endcase
        end
        in_stb = 1'b0;
    endtask

    // Edge at phase 7. The hard instance restarts at phase 1 and strobes
    // 2 ticks later. The soft instance moves only by 1 and strobes at
    // tick 19. A second edge lands on the hard instance's sample phase:
    // that strobe is kept, and a re-aligned one follows two ticks later.
    task automatic test_hard_sync();
        do_reset();
        for (int k = 1; k <= 27; k++) begin
            in_stb = (k == 8 || k == 25);
            tick();
            case (k)
                3:  begin total++; if (h_stb !== 1'b1) begin bad++; $display("FAIL hard_stb_3: got %0b want 1", h_stb); end end
                9:  begin total++; if (h_stb !== 1'b0) begin bad++; $display("FAIL hard_stb_9: got %0b want 0", h_stb); end end
                10: begin
                    total++; if (h_stb !== 1'b1) begin bad++; $display("FAIL hard_stb_10: got %0b want 1", h_stb); end
                    total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL hs_soft_stb_10: got %0b want 0", s_stb); end
                end
                18: begin total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL hs_soft_stb_18: got %0b want 0", s_stb); end end
                19: begin total++; if (s_stb !== 1'b1) begin bad++; $display("FAIL hs_soft_stb_19: got %0b want 1", s_stb); end end
                24: begin total++; if (h_stb !== 1'b0) begin bad++; $display("FAIL hard_stb_24: got %0b want 0", h_stb); end end
                25: begin total++; if (h_stb !== 1'b1) begin bad++; $display("FAIL hard_stb_coinc: got %0b want 1", h_stb); end end
                26: begin total++; if (h_stb !== 1'b0) begin bad++; $display("FAIL hard_stb_26: got %0b want 0", h_stb); end end
                27: begin total++; if (h_stb !== 1'b1) begin bad++; $display("FAIL hard_stb_27: got %0b want 1", h_stb); end end
                default: ;
            endcase
        end
        in_stb = 1'b0;
    endtask

    // Lock with 16 edges at phase 0 (ticks 16..241), then silence. Wraps
    // occur at ticks 255 + 15j, so the 32nd wrap is at tick 720. A lone
    // edge at tick 730 clears los but does not restore lock.
    task automatic test_los();
        do_reset();
        for (int k = 1; k <= 735; k++) begin
            in_stb = ((k >= 16 && k <= 241 && ((k - 16) % 15) == 0) || k == 730);
            tick();
            case (k)
                240: begin total++; if (s_locked !== 1'b0) begin bad++; $display("FAIL los_lock_pre: got %0b want 0", s_locked); end end
                241: begin total++; if (s_locked !== 1'b1 || h_locked !== 1'b1) begin bad++; $display("FAIL los_lock: got soft=%0b hard=%0b want 1 1", s_locked, h_locked); end end
                719: begin total++; if (s_los !== 1'b0 || s_locked !== 1'b1) begin bad++; $display("FAIL los_719: got los=%0b locked=%0b want 0 1", s_los, s_locked); end end
                720: begin
                    total++; if (s_los !== 1'b1 || s_locked !== 1'b0) begin bad++; $display("FAIL los_720: got los=%0b locked=%0b want 1 0", s_los, s_locked); end
                    total++; if (h_los !== 1'b1 || h_locked !== 1'b0) begin bad++; $display("FAIL los_720_hard: got los=%0b locked=%0b want 1 0", h_los, h_locked); end
                end
                729: begin total++; if (s_los !== 1'b1) begin bad++; $display("FAIL los_729: got %0b want 1", s_los); end end
                730: begin total++; if (s_los !== 1'b0 || s_locked !== 1'b0 || h_los !== 1'b0) begin bad++; $display("FAIL los_recover: got los=%0b locked=%0b hlos=%0b want 0 0 0", s_los, s_locked, h_los); end end
                735: begin total++; if (s_locked !== 1'b0) begin bad++; $display("FAIL los_nolock: got %0b want 0", s_locked); end end
                default: ;
            endcase
        end
        in_stb = 1'b0;
    endtask

    // A reset pulse, with in_stb high, lands on the tick where a strobe
    // would otherwise fire. The strobe must not appear, and all state must
    // restart from the reset values.
    task automatic test_rst_mid();
        do_reset();
        in_hi = 1'b1; in_lo = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            in_stb = (k == 16 || k == 18);
            rst = (k == 18);
            tick();
            case (k)
                3:  begin total++; if (s_hi !== 1'b1 || s_lo !== 1'b1) begin bad++; $display("FAIL mid_sample: got %0b%0b want 11", s_hi, s_lo); end end
                16: begin total++; if (s_los !== 1'b0) begin bad++; $display("FAIL mid_los_clear: got %0b want 0", s_los); end end
                18: begin
                    total++; if (s_stb !== 1'b0 || h_stb !== 1'b0) begin bad++; $display("FAIL mid_rst_stb: got soft=%0b hard=%0b want 0 0", s_stb, h_stb); end
                    total++; if (s_los !== 1'b1 || h_los !== 1'b1) begin bad++; $display("FAIL mid_rst_los: got soft=%0b hard=%0b want 1 1", s_los, h_los); end
                    total++; if (s_hi !== 1'b0 || s_lo !== 1'b0) begin bad++; $display("FAIL mid_rst_data: got %0b%0b want 00", s_hi, s_lo); end
                end
                19, 20: begin total++; if (s_stb !== 1'b0) begin bad++; $display("FAIL mid_restart_k%0d: got %0b want 0", k, s_stb); end end
                21: begin total++; if (s_stb !== 1'b1 || h_stb !== 1'b1) begin bad++; $display("FAIL mid_restart_stb: got soft=%0b hard=%0b want 1 1", s_stb, h_stb); end end
                default: ;
            endcase
        end
        rst = 1'b0;
        in_stb = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_hi = 1'b0;
        in_lo = 1'b0;
        in_stb = 1'b0;
        test_reset();
        test_soft_lock();
        test_hard_sync();
        test_los();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
